pattern_pwm_seq: RTL and testbench
==================================

PATTERN_PWM_SEQ -- requirements
Module: pattern_pwm_seq

Interface
REQ-001 The block SHALL have parameter PAT_WIDTH, default 32, giving the pattern bits per channel.
REQ-002 The block SHALL have parameter N_CH, default 4, giving the number of output channels sharing one timeline.
REQ-003 The block SHALL have parameter DUTY_WIDTH, default 16, giving the per-bit hold counter width.
REQ-004 The block SHALL have parameter LEN_WIDTH, default 5, with 2^LEN_WIDTH >= PAT_WIDTH.
REQ-005 The block SHALL have parameter REP_WIDTH, default 8, giving the repeat counter width.
REQ-006 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 Port start, input, 1 bit: request to begin a sequence; sampled only in IDLE.
REQ-009 Port stop, input, 1 bit: abort request; sampled in every state.
REQ-010 Port duty_num, input, DUTY_WIDTH: each pattern bit is held duty_num+1 cycles.
REQ-011 Port pat_len, input, LEN_WIDTH: index of the last pattern bit played (length = pat_len+1).
REQ-012 Port rep_num, input, REP_WIDTH: number of pattern passes; 0 = continuous.
REQ-013 Port pat, input, N_CH*PAT_WIDTH: channel c pattern is pat[c*PAT_WIDTH +: PAT_WIDTH], bit 0 played first.
REQ-014 Port idle_level, input, N_CH: per-channel output level when not running.
REQ-015 Port pwm_out, output, N_CH: registered channel outputs.
REQ-016 Port busy, output, 1 bit: high while a sequence runs.
REQ-017 Port done, output, 1 bit: one-cycle pulse on natural completion.
REQ-018 Port aborted, output, 1 bit: one-cycle pulse when a running sequence is stopped.
REQ-019 Port bit_idx, output, LEN_WIDTH: index of the pattern bit currently driven.
REQ-020 Port rep_cnt, output, REP_WIDTH: completed passes in the current sequence.

Function
REQ-021 The FSM SHALL have states IDLE and RUN only.
REQ-022 In IDLE, start=1 and stop=0 at edge k SHALL latch duty_num, pat_len, rep_num and pat, enter RUN, and after edge k set busy=1, bit_idx=0, rep_cnt=0 and pwm_out[c]=pat[c*PAT_WIDTH].
REQ-023 Config inputs changing during RUN SHALL have no effect until the next start.
REQ-024 pat_len greater than PAT_WIDTH-1 SHALL be clamped to PAT_WIDTH-1 at latch time.
REQ-025 In RUN each bit SHALL drive pwm_out for exactly duty_num+1 cycles; the hold counter then resets to 0 and bit_idx increments, and pwm_out takes the new bit on the same edge.
REQ-026 After bit pat_len, bit_idx SHALL wrap to 0 and rep_cnt SHALL increment if rep_num=0 or rep_cnt+1 < rep_num.
REQ-027 In continuous mode rep_cnt SHALL wrap modulo 2^REP_WIDTH, and the sequence SHALL run until stop.
REQ-028 Otherwise, after the last hold cycle of bit pat_len in pass rep_num, the next edge SHALL return to IDLE with busy=0, pwm_out=idle_level, done=1 for one cycle, and bit_idx=0.
REQ-029 A finite run SHALL last exactly (pat_len+1)*(duty_num+1)*rep_num cycles of busy=1.
REQ-030 start while busy SHALL be ignored; start in the cycle done is asserted SHALL be accepted (IDLE at that edge).
REQ-031 stop=1 in RUN SHALL, at the next edge, force IDLE, busy=0, pwm_out=idle_level, aborted=1 for one cycle, and done=0, even if that edge would have been natural completion.
REQ-032 stop=1 together with start=1 in IDLE SHALL leave the block in IDLE with no pulse.
REQ-033 In IDLE, pwm_out SHALL follow idle_level with one cycle latency.

Reset
REQ-034 While rst=1, the block SHALL hold state IDLE, pwm_out=0, busy=0, done=0, aborted=0, bit_idx=0, rep_cnt=0, and all latched config and counters at 0, regardless of clk.
REQ-035 Reset asserted mid-RUN SHALL abort without done or aborted pulses; after release the block SHALL wait in IDLE for start.

Verification
REQ-036 N_CH=1, pat=0b1011, pat_len=3, duty_num=1, rep_num=1, start pulse -> pwm_out 1,1,1,1,0,0,1,1; busy high 8 cycles; done one cycle after the last bit; pwm_out=idle_level.
REQ-037 pat_len=1, duty_num=0, rep_num=3, ch0 pat=0b10 -> pwm_out 0,1,0,1,0,1; rep_cnt 0,0,1,1,2,2; one done pulse.
REQ-038 rep_num=0, pat_len=2, duty_num=2, stop asserted after 20 cycles -> output pattern repeats every 9 cycles until stop; aborted pulses once; no done.
REQ-039 Repeat REQ-036 with N_CH=4 and distinct per-channel patterns, changing pat and duty_num mid-run, plus a second start while busy -> all channels aligned, outputs unaffected by mid-run changes, second start ignored.
REQ-040 pat_len=31 with PAT_WIDTH=8, duty_num=0, rep_num=1 -> 8 bits played, busy 8 cycles.
REQ-041 rst pulsed mid-run -> all outputs 0 immediately; no pulses; a later start runs normally.

Source files
------------

// File: rtl/pattern_pwm_seq.sv
// -----------------------------------------------------------------------------
// pattern_pwm_seq
//   Plays a latched per-channel bit pattern on N_CH outputs that share one
//   timeline. Each pattern bit is held for duty_num+1 cycles. A pass covers
//   bits 0..pat_len, and the block runs rep_num passes (0 = run until stopped).
//
// Ports
//   clk         : clock, rising edge
//   rst         : asynchronous active-high reset
//   start       : begin a sequence (sampled only when idle)
//   stop        : abort a running sequence; also blocks a start when idle
//   duty_num    : hold count per bit minus one
//   pat_len     : index of the last bit played (clamped to PAT_WIDTH-1)
//   rep_num     : number of passes, 0 = continuous
//   pat         : channel c pattern in pat[c*PAT_WIDTH +: PAT_WIDTH], bit 0 first
//   idle_level  : per-channel output level while idle
//   pwm_out     : registered channel outputs
//   busy        : high while a sequence runs
//   done        : one-cycle pulse on natural completion
//   aborted     : one-cycle pulse when stop ends a running sequence
//   bit_idx     : index of the bit currently driven
//   rep_cnt     : completed passes in the current sequence
// -----------------------------------------------------------------------------
module pattern_pwm_seq #(
   parameter int PAT_WIDTH  = 32,
   parameter int N_CH       = 4,
   parameter int DUTY_WIDTH = 16,
   parameter int LEN_WIDTH  = 5,
   parameter int REP_WIDTH  = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      stop,
   input  logic [DUTY_WIDTH-1:0]     duty_num,
   input  logic [LEN_WIDTH-1:0]      pat_len,
   input  logic [REP_WIDTH-1:0]      rep_num,
   input  logic [N_CH*PAT_WIDTH-1:0] pat,
   input  logic [N_CH-1:0]           idle_level,
   output logic [N_CH-1:0]           pwm_out,
   output logic                      busy,
   output logic                      done,
   output logic                      aborted,
   output logic [LEN_WIDTH-1:0]      bit_idx,
   output logic [REP_WIDTH-1:0]      rep_cnt
);

   // Patterns are widened to the full bit_idx range so any index is in bounds.
   localparam int                   PAD_W   = 2 ** LEN_WIDTH;
   localparam logic [LEN_WIDTH-1:0] MAX_IDX = LEN_WIDTH'(PAT_WIDTH - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                    r_state;
   logic [DUTY_WIDTH-1:0]     r_duty;
   logic [DUTY_WIDTH-1:0]     r_hold;
   logic [LEN_WIDTH-1:0]      r_len;
   logic [REP_WIDTH-1:0]      r_rep;
   logic [N_CH*PAT_WIDTH-1:0] r_pat;

   logic                      w_bit_end;
   logic                      w_pass_end;
   logic                      w_last_pass;
   logic [REP_WIDTH:0]        w_rep_inc;
   logic [LEN_WIDTH-1:0]      w_next_idx;
   logic [LEN_WIDTH-1:0]      w_len_clamp;
   logic [N_CH-1:0]           w_next_bits;
   logic [N_CH-1:0]           w_first_bits;

   assign w_bit_end   = (r_hold == r_duty);
   assign w_pass_end  = w_bit_end && (bit_idx == r_len);
   // One bit wider so rep_cnt+1 cannot wrap before comparing with rep_num.
   assign w_rep_inc   = {1'b0, rep_cnt} + (REP_WIDTH+1)'(1);
   assign w_last_pass = (r_rep != '0) && (w_rep_inc >= {1'b0, r_rep});
   assign w_next_idx  = w_pass_end ? '0 : bit_idx + LEN_WIDTH'(1);
   assign w_len_clamp = (pat_len > MAX_IDX) ? MAX_IDX : pat_len;

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
         logic [PAT_WIDTH-1:0] w_ch_pat;
         logic [PAD_W-1:0]     w_ch_pad;
         assign w_ch_pat         = r_pat[gi*PAT_WIDTH +: PAT_WIDTH];
         assign w_ch_pad         = PAD_W'(w_ch_pat);
         assign w_next_bits[gi]  = w_ch_pad[w_next_idx];
         // First bit comes straight from the input so it shows on the start edge.
         assign w_first_bits[gi] = pat[gi*PAT_WIDTH];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_duty  <= '0;
         r_hold  <= '0;
         r_len   <= '0;
         r_rep   <= '0;
         r_pat   <= '0;
         pwm_out <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         aborted <= 1'b0;
         bit_idx <= '0;
         rep_cnt <= '0;
      end else begin
         done    <= 1'b0;
         aborted <= 1'b0;
         case (r_state)
            IDLE: begin
               pwm_out <= idle_level;
               bit_idx <= '0;
               if (start && !stop) begin
                  r_duty  <= duty_num;
                  r_len   <= w_len_clamp;
                  r_rep   <= rep_num;
                  r_pat   <= pat;
                  r_hold  <= '0;
                  rep_cnt <= '0;
                  busy    <= 1'b1;
                  pwm_out <= w_first_bits;
                  r_state <= RUN;
               end
            end
            RUN: begin
               if (stop) begin
                  // Abort wins over a completion falling on the same edge.
                  r_state <= IDLE;
                  busy    <= 1'b0;
                  aborted <= 1'b1;
                  pwm_out <= idle_level;
                  bit_idx <= '0;
                  r_hold  <= '0;
               end else if (w_bit_end) begin
                  r_hold <= '0;
                  if (w_pass_end && w_last_pass) begin
                     r_state <= IDLE;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     pwm_out <= idle_level;
                     bit_idx <= '0;
                  end else begin
                     bit_idx <= w_next_idx;
                     pwm_out <= w_next_bits;
                     if (w_pass_end) begin
                        rep_cnt <= w_rep_inc[REP_WIDTH-1:0];
                     end
                  end
               end else begin
                  r_hold <= r_hold + DUTY_WIDTH'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_pwm_seq.sv
// -----------------------------------------------------------------------------
// tb_pattern_pwm_seq
//   Scoreboard bench: each sequence's expected per-cycle outputs are built from
//   a small behavioural model when the stimulus is driven and queued; a monitor
//   pops and compares one entry per falling clock edge.
// -----------------------------------------------------------------------------
module tb_pattern_pwm_seq;

   localparam int PW = 8;
   localparam int NC = 4;
   localparam int DW = 8;
   localparam int LW = 5;
   localparam int RW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          stop;
   logic [DW-1:0] duty_num;
   logic [LW-1:0] pat_len;
   logic [RW-1:0] rep_num;
   logic [NC*PW-1:0] pat;
   logic [NC-1:0] idle_level;
   logic [NC-1:0] pwm_out;
   logic          busy;
   logic          done;
   logic          aborted;
   logic [LW-1:0] bit_idx;
   logic [RW-1:0] rep_cnt;

   always #5 clk = ~clk;

   pattern_pwm_seq #(
      .PAT_WIDTH (PW),
      .N_CH      (NC),
      .DUTY_WIDTH(DW),
      .LEN_WIDTH (LW),
      .REP_WIDTH (RW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .duty_num  (duty_num),
      .pat_len   (pat_len),
      .rep_num   (rep_num),
      .pat       (pat),
      .idle_level(idle_level),
      .pwm_out   (pwm_out),
      .busy      (busy),
      .done      (done),
      .aborted   (aborted),
      .bit_idx   (bit_idx),
      .rep_cnt   (rep_cnt)
   );

   typedef struct packed {
      logic [NC-1:0] pwm;
      logic          busy;
      logic          done;
      logic          aborted;
      logic [LW-1:0] idx;
      logic [RW-1:0] rep;
      logic          chk_rep;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance to just after the next n falling edges (monitor has sampled).
   task automatic wait_n(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic push_idle(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e = '0;
         e.pwm = idle_level;
         exp_q.push_back(e);
      end
   endtask

   // tail: 0 none, 1 done+idle, 2 done only, 3 aborted+idle.
   // cut > 0 limits the number of busy cycles queued.
   task automatic push_run(input logic [31:0] p, input int len, input int duty,
                           input int rep, input int cut, input int tail);
      exp_t e;
      int   lc;
      int   cyc;
      int   pass;
      bit   fin;
      lc   = (len > PW-1) ? PW-1 : len;
      cyc  = 0;
      pass = 0;
      fin  = 1'b0;
      $display("txn len=%0d duty=%0d rep=%0d cut=%0d pat=%08h", len, duty, rep, cut, p);
      while (!fin) begin
         for (int b = 0; b <= lc; b++) begin
            for (int h = 0; h <= duty; h++) begin
               if (!fin) begin
                  e = '0;
                  for (int c = 0; c < NC; c++) e.pwm[c] = p[c*PW + b];
                  e.busy    = 1'b1;
                  e.idx     = LW'(b);
                  e.rep     = RW'(pass);
                  e.chk_rep = 1'b1;
                  exp_q.push_back(e);
                  cyc++;
                  if (cut > 0 && cyc == cut) fin = 1'b1;
               end
            end
         end
         pass++;
         if (rep != 0 && pass == rep) fin = 1'b1;
      end
      if (tail != 0) begin
         e = '0;
         e.pwm = idle_level;
         if (tail == 3) e.aborted = 1'b1;
         else           e.done    = 1'b1;
         exp_q.push_back(e);
         if (tail != 2) push_idle(1);
      end
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 300) begin
         wait_n(1);
         guard++;
      end
      if (exp_q.size() != 0) begin
         check_val("drain_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
   endtask

   task automatic check_reset_outs(input string tag);
      check_val({tag, "_pwm"},  32'(pwm_out), 32'd0);
      check_val({tag, "_busy"}, 32'(busy),    32'd0);
      check_val({tag, "_done"}, 32'(done),    32'd0);
      check_val({tag, "_abrt"}, 32'(aborted), 32'd0);
      check_val({tag, "_idx"},  32'(bit_idx), 32'd0);
      check_val({tag, "_rep"},  32'(rep_cnt), 32'd0);
   endtask

   always @(negedge clk) begin
      if (!rst && exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check_val("pwm_out", 32'(pwm_out), 32'(mon_e.pwm));
         check_val("busy",    32'(busy),    32'(mon_e.busy));
         check_val("done",    32'(done),    32'(mon_e.done));
         check_val("aborted", 32'(aborted), 32'(mon_e.aborted));
         check_val("bit_idx", 32'(bit_idx), 32'(mon_e.idx));
         if (mon_e.chk_rep) check_val("rep_cnt", 32'(rep_cnt), 32'(mon_e.rep));
      end
   end

   task automatic go(input logic [31:0] p, input int len, input int duty, input int rep);
      pat      = p;
      pat_len  = LW'(len);
      duty_num = DW'(duty);
      rep_num  = RW'(rep);
      start    = 1'b1;
   endtask

   initial begin
      logic [31:0] p;
      rst        = 1'b0;
      start      = 1'b0;
      stop       = 1'b0;
      duty_num   = '0;
      pat_len    = '0;
      rep_num    = '0;
      pat        = '0;
      idle_level = '0;
      #1 rst = 1'b1;
      #1 check_reset_outs("rst_async");
      wait_n(2);
      check_reset_outs("rst_held");
      rst = 1'b0;

      // Idle output follows idle_level one cycle later
      idle_level = 4'b1010;
      push_idle(2);
      wait_n(2);
      idle_level = 4'b0101;
      push_idle(2);
      wait_n(2);
      drain();

      // Single-channel pattern 1011, two cycles per bit, one pass
      p = 32'h0000_000B;
      go(p, 3, 1, 1);
      push_run(p, 3, 1, 1, 0, 1);
      wait_n(1); start = 1'b0;
      drain();

      // Three passes of 0b10, one cycle per bit
      p = 32'h0000_0002;
      go(p, 1, 0, 3);
      push_run(p, 1, 0, 3, 0, 1);
      wait_n(1); start = 1'b0;
      drain();

      // Continuous, period 9, stopped after 20 busy cycles
      p = 32'h0503_0601;
      go(p, 2, 2, 0);
      push_run(p, 2, 2, 0, 20, 3);
      wait_n(1);  start = 1'b0;
      wait_n(19); stop  = 1'b1;
      wait_n(1);  stop  = 1'b0;
      drain();

      // Continuous single-bit pattern: rep_cnt wraps past 15
      p = 32'h0100_0101;
      go(p, 0, 0, 0);
      push_run(p, 0, 0, 0, 20, 3);
      wait_n(1);  start = 1'b0;
      wait_n(19); stop  = 1'b1;
      wait_n(1);  stop  = 1'b0;
      drain();

      // Four channels; config changes and a second start while busy are ignored
      p = 32'hC35A_0F0B;
      go(p, 3, 1, 1);
      push_run(p, 3, 1, 1, 0, 1);
      wait_n(1); start = 1'b0;
      wait_n(2);
      pat = ~p; duty_num = 8'd5; pat_len = 5'd7; rep_num = 4'd9; start = 1'b1;
      wait_n(1); start = 1'b0;
      drain();

      // Oversized pat_len clamps to the full 8-bit pattern
      p = 32'h3C96_A5E1;
      go(p, 31, 0, 1);
      push_run(p, 31, 0, 1, 0, 1);
      wait_n(1); start = 1'b0;
      drain();

      // Start held in the done cycle is accepted immediately
      p = 32'h0201_0302;
      go(p, 1, 0, 1);
      push_run(p, 1, 0, 1, 0, 2);
      wait_n(1); start = 1'b0;
      wait_n(2);
      p = 32'h0507_0205;
      go(p, 2, 0, 1);
      push_run(p, 2, 0, 1, 0, 1);
      wait_n(1); start = 1'b0;
      drain();

      // Stop on the natural-completion edge gives aborted, not done
      p = 32'h0102_0301;
      go(p, 1, 0, 1);
      push_run(p, 1, 0, 1, 2, 3);
      wait_n(1); start = 1'b0;
      wait_n(1); stop  = 1'b1;
      wait_n(1); stop  = 1'b0;
      drain();

      // Start together with stop in idle: nothing happens
      start = 1'b1; stop = 1'b1;
      push_idle(3);
      wait_n(3);
      start = 1'b0; stop = 1'b0;
      drain();

      // Reset mid-run: outputs clear at once, no pulses, later run is normal
      p = 32'h0F0E_0D0C;
      go(p, 3, 3, 2);
      push_run(p, 3, 3, 2, 5, 0);
      wait_n(1); start = 1'b0;
      wait_n(4);
      drain();
      #2 rst = 1'b1;
      #1 check_reset_outs("rst_midrun");
      repeat (3) begin
         @(negedge clk);
         check_reset_outs("rst_hold");
      end
      #1 rst = 1'b0;
      push_idle(2);
      wait_n(2);
      drain();
      p = 32'h0009_000B;
      go(p, 3, 1, 1);
      push_run(p, 3, 1, 1, 0, 1);
      wait_n(1); start = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
